// File: rtl/gelu_stream_if.sv
// Bundles the source-read, gelu LUT and destination-write ports of the sequencer.
// Signal suffixes are from the sequencer's point of view (master side).
interface gelu_stream_if #(
    parameter int ADDR_W = 10
);
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [7:0]        rd_data_i;
    logic [1:0]        gelu_layer_o;
    logic [7:0]        gelu_in_o;
    logic [7:0]        gelu_out_i;
    logic              wr_valid_o;
    logic              wr_ready_i;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;

    modport master (
        output rd_en_o, rd_addr_o, gelu_layer_o, gelu_in_o, wr_valid_o, wr_addr_o, wr_data_o,
        input  rd_data_i, gelu_out_i, wr_ready_i
    );

    modport slave (
        input  rd_en_o, rd_addr_o, gelu_layer_o, gelu_in_o, wr_valid_o, wr_addr_o, wr_data_o,
        output rd_data_i, gelu_out_i, wr_ready_i
    );
endinterface

// File: rtl/gelu_stream_ctrl.sv
// Streams a vector of int8 activations through the shared gelu LUT into the
// destination buffer; a credit-limited skid FIFO covers the 2-cycle read+LUT latency.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | issuing reads while credits allow
// DRAIN | all reads issued, waiting for the last write handshake
// DONE  | one-cycle completion pulse
module gelu_stream_ctrl #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int FIFO_D = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      layer_i,
    input  logic [ADDR_W:0] len_i,
    output logic            busy_o,
    output logic            done_o,
    gelu_stream_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int              PW       = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int              CW       = $clog2(FIFO_D + 1);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L    = (ADDR_W + 1)'(1);
    localparam logic [CW:0]     FIFO_L   = (CW + 1)'(FIFO_D);
    localparam logic [PW-1:0]   PTR_LAST = PW'(FIFO_D - 1);

    state_e            state_q, state_d;
    logic [1:0]        layer_q, layer_d;
    logic [ADDR_W:0]   len_q, len_d, rd_idx_q, rd_idx_d;
    logic [ADDR_W:0]   len_clamp, len_last;
    logic              v1_q, v2_q;
    logic [ADDR_W-1:0] idx1_q, idx2_q;
    logic [7:0]        fifo_data_q [FIFO_D];
    logic [ADDR_W-1:0] fifo_addr_q [FIFO_D];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic [CW:0]       credit;
    logic              rd_en, push, pop, wr_valid;

    // Occupancy plus the two reads still in the pipeline must stay below the FIFO depth.
    always_comb begin
        len_clamp = (len_i > DEPTH_L) ? DEPTH_L : len_i;
        len_last  = len_q - ONE_L;
        credit    = {1'b0, count_q} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q};
        rd_en     = (state_q == RUN) && (credit < FIFO_L);
        push      = v2_q;
        wr_valid  = (count_q != '0);
        pop       = wr_valid && bus.wr_ready_i;
    end

    always_comb begin
        state_d  = state_q;
        layer_d  = layer_q;
        len_d    = len_q;
        rd_idx_d = rd_idx_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    layer_d  = layer_i;
                    len_d    = len_clamp;
                    rd_idx_d = '0;
                    state_d  = (len_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (rd_en) begin
                    rd_idx_d = rd_idx_q + ONE_L;
                    if (rd_idx_q == len_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && ({1'b0, fifo_addr_q[rptr_q]} == len_last)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            len_q    <= '0;
            rd_idx_q <= '0;
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            idx1_q   <= '0;
            idx2_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            layer_q  <= layer_d;
            len_q    <= len_d;
            rd_idx_q <= rd_idx_d;
            v1_q     <= rd_en;
            v2_q     <= v1_q;
            idx1_q   <= rd_idx_q[ADDR_W-1:0];
            idx2_q   <= idx1_q;
            if (push) wptr_q <= (wptr_q == PTR_LAST) ? '0 : wptr_q + PW'(1);
            if (pop)  rptr_q <= (rptr_q == PTR_LAST) ? '0 : rptr_q + PW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data_q[wptr_q] <= bus.gelu_out_i;
            fifo_addr_q[wptr_q] <= idx2_q;
        end
    end

    // Head outputs are forced to zero when empty so the write port reads 0 after reset.
    always_comb begin
        busy_o           = (state_q == RUN) || (state_q == DRAIN);
        done_o           = (state_q == DONE);
        bus.rd_en_o      = rd_en;
        bus.rd_addr_o    = rd_idx_q[ADDR_W-1:0];
        bus.gelu_layer_o = layer_q;
        bus.gelu_in_o    = bus.rd_data_i;
        bus.wr_valid_o   = wr_valid;
        bus.wr_addr_o    = wr_valid ? fifo_addr_q[rptr_q] : '0;
        bus.wr_data_o    = wr_valid ? fifo_data_q[rptr_q] : '0;
    end
endmodule

// File: tb/tb_gelu_stream_ctrl.sv
// Bench for gelu_stream_ctrl: models the source buffer and gelu LUT, logs every
// read/write/done event, and compares jobs against a per-element reference.
`timescale 1ns/1ps
module tb_gelu_stream_ctrl;
    localparam int DEPTH = 1024, ADDR_W = 10, FIFO_D = 4;

    logic            clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic [1:0]      layer_i = '0;
    logic [ADDR_W:0] len_i = '0;
    logic            busy_o, done_o;

    gelu_stream_if #(.ADDR_W(ADDR_W)) bus ();

    gelu_stream_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FIFO_D(FIFO_D)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .layer_i(layer_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o), .bus(bus)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    logic [7:0] src [DEPTH];

    function automatic logic [7:0] lut(input logic [1:0] l, input logic [7:0] x);
        logic [7:0] m;
        m = {5'd0, l, 1'b1} + 8'd2;
        return (x * m) ^ {l, 6'h2b};
    endfunction

    // Source buffer (1-cycle read) and gelu LUT (1-cycle lookup)
    always @(posedge clk_i) begin
        if (bus.rd_en_o) bus.rd_data_i <= src[bus.rd_addr_o];
        bus.gelu_out_i <= lut(bus.gelu_layer_o, bus.gelu_in_o);
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int         wr_cyc[$], wr_adr[$], rd_cyc[$], rd_adr[$], done_cyc[$];
    logic [7:0] wr_dat[$];
    int         busy_cnt = 0, credit_viol = 0, stab_viol = 0, layer_viol = 0;
    int         reads_tot = 0, pops_tot = 0, prev_adr = 0;
    logic [1:0] exp_layer = '0;
    logic [7:0] prev_dat = '0;
    bit         prev_stall = 1'b0;

    always @(negedge clk_i) begin
        if (reads_tot - pops_tot + int'(bus.rd_en_o) > FIFO_D) credit_viol++;
        if (prev_stall && (!bus.wr_valid_o || int'(bus.wr_addr_o) != prev_adr || bus.wr_data_o != prev_dat))
            stab_viol++;
        if (busy_o && bus.gelu_layer_o != exp_layer) layer_viol++;
        if (busy_o) busy_cnt++;
        if (done_o) done_cyc.push_back(cyc);
        if (bus.rd_en_o) begin
            rd_cyc.push_back(cyc); rd_adr.push_back(int'(bus.rd_addr_o)); reads_tot++;
        end
        if (bus.wr_valid_o && bus.wr_ready_i) begin
            wr_cyc.push_back(cyc); wr_adr.push_back(int'(bus.wr_addr_o));
            wr_dat.push_back(bus.wr_data_o); pops_tot++;
        end
        prev_stall = bus.wr_valid_o && !bus.wr_ready_i && !rst_i;
        prev_adr   = int'(bus.wr_addr_o);
        prev_dat   = bus.wr_data_o;
        if (rst_i) begin reads_tot = 0; pops_tot = 0; end
    end

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 1) return !(k >= 3 && k <= 12);
        if (mode == 2) return ($urandom_range(0, 3) != 0);
        return 1'b1;
    endfunction

    int          t0 = 0;
    bit          tmo = 1'b0;
    logic [33:0] snap = '0;

    // mode: 0 ready, 1 stall 3..12, 2 random ready, 3 stray start at 4, 4 reset at 5, 5 start in DONE
    task automatic run_job(input int len, input int layer, input int mode, input int budget);
        int db;
        db = done_cyc.size();
        @(posedge clk_i); #1;
        start_i = 1'b1; len_i = (ADDR_W + 1)'(len); layer_i = 2'(layer); t0 = cyc;
        exp_layer = 2'(layer);
        bus.wr_ready_i = ready_for(mode, 0);
        tmo = 1'b1;
        for (int k = 1; k < budget; k++) begin
            @(posedge clk_i); #1;
            if (done_cyc.size() > db) begin tmo = 1'b0; break; end
            start_i = (mode == 3 && k == 4) || (mode == 5 && k == 1);
            if (start_i) begin
                len_i = (mode == 3) ? 11'd3 : 11'd5; layer_i = 2'd3;
            end else begin
                len_i = (ADDR_W + 1)'($urandom); layer_i = 2'($urandom);
            end
            rst_i = (mode == 4 && k == 5);
            if (mode == 4 && k == 6)
                snap = {busy_o, done_o, bus.rd_en_o, bus.wr_valid_o, bus.rd_addr_o,
                        bus.gelu_layer_o, bus.wr_addr_o, bus.wr_data_o};
            bus.wr_ready_i = ready_for(mode, k);
        end
        start_i = 1'b0; rst_i = 1'b0; bus.wr_ready_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; bus.wr_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if ({busy_o, done_o, bus.rd_en_o, bus.wr_valid_o} !== 4'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {busy_o, done_o, bus.rd_en_o, bus.wr_valid_o}); end
        total++; if (bus.rd_addr_o !== '0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr_o); end
        total++; if (bus.gelu_layer_o !== 2'd0) begin bad++; $display("FAIL reset_layer: got %0d want 0", bus.gelu_layer_o); end
        total++; if ({bus.wr_addr_o, bus.wr_data_o} !== '0) begin
            bad++; $display("FAIL reset_wr: got addr=%0d data=%0h want 0/0", bus.wr_addr_o, bus.wr_data_o); end
        rst_i = 1'b0;
    endtask

    task automatic test_basic();
        int rb, wb, bb, nr, nw, errs, fi;
        for (int i = 0; i < DEPTH; i++) src[i] = 8'(i) ^ 8'h55;
        rb = rd_cyc.size(); wb = wr_cyc.size(); bb = busy_cnt;
        run_job(8, 2, 0, 40);
        nr = rd_cyc.size() - rb; nw = wr_cyc.size() - wb;
        total++; if (tmo) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++; if (nr != 8) begin bad++; $display("FAIL basic_rd_count: got %0d want 8", nr); end
        errs = 0; fi = -1;
        for (int i = 0; i < nr; i++)
            if (rd_cyc[rb+i] - t0 != i + 1 || rd_adr[rb+i] != i) begin errs++; if (fi < 0) fi = i; end
        total++; if (errs != 0) begin bad++; $display("FAIL basic_rd: read %0d got cyc=%0d addr=%0d want cyc=%0d addr=%0d",
            fi, rd_cyc[rb+fi] - t0, rd_adr[rb+fi], fi + 1, fi); end
        total++; if (nw != 8) begin bad++; $display("FAIL basic_wr_count: got %0d want 8", nw); end
        errs = 0; fi = -1;
        for (int i = 0; i < nw; i++)
            if (wr_cyc[wb+i] - t0 != i + 4 || wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'd2, 8'(i) ^ 8'h55)) begin
                errs++; if (fi < 0) fi = i; end
        total++; if (errs != 0) begin bad++; $display("FAIL basic_wr: write %0d got cyc=%0d addr=%0d data=%0h want cyc=%0d addr=%0d data=%0h",
            fi, wr_cyc[wb+fi] - t0, wr_adr[wb+fi], wr_dat[wb+fi], fi + 4, fi, lut(2'd2, 8'(fi) ^ 8'h55)); end
        total++; if (tmo || done_cyc[$] - t0 != 12) begin bad++; $display("FAIL basic_done: got cycle %0d want 12", done_cyc[$] - t0); end
        total++; if (busy_cnt - bb != 11) begin bad++; $display("FAIL basic_busy: got %0d cycles want 11", busy_cnt - bb); end
    endtask

    task automatic test_backpressure();
        int rb, wb, cv, sv, nw, early, errs, fi, lay;
        lay = $urandom_range(0, 3);
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        rb = rd_cyc.size(); wb = wr_cyc.size(); cv = credit_viol; sv = stab_viol;
        run_job(16, lay, 1, 80);
        nw = wr_cyc.size() - wb;
        early = 0;
        for (int i = rb; i < rd_cyc.size(); i++) if (rd_cyc[i] - t0 <= 12) early++;
        total++; if (tmo) begin bad++; $display("FAIL bp_timeout: got no done want done"); end
        total++; if (early != 4) begin bad++; $display("FAIL bp_reads_during_stall: got %0d want 4", early); end
        total++; if (credit_viol != cv) begin bad++; $display("FAIL bp_credit: got %0d overruns want 0", credit_viol - cv); end
        total++; if (stab_viol != sv) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stab_viol - sv); end
        total++; if (nw != 16) begin bad++; $display("FAIL bp_wr_count: got %0d want 16", nw); end
        total++; if (nw == 0 || wr_cyc[wb] - t0 != 13) begin bad++; $display("FAIL bp_first_wr: got cycle %0d want 13", wr_cyc[wb] - t0); end
        errs = 0; fi = -1;
        for (int i = 0; i < nw; i++)
            if (wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'(lay), src[i])) begin errs++; if (fi < 0) fi = i; end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_data: write %0d got addr=%0d data=%0h want addr=%0d data=%0h",
            fi, wr_adr[wb+fi], wr_dat[wb+fi], fi, lut(2'(lay), src[fi])); end
        total++; if (tmo || done_cyc[$] - wr_cyc[$] != 1) begin
            bad++; $display("FAIL bp_done: got %0d cycles after last write want 1", done_cyc[$] - wr_cyc[$]); end
    endtask

    task automatic test_zero_len();
        int rb, wb, bb, db;
        rb = rd_cyc.size(); wb = wr_cyc.size(); bb = busy_cnt; db = done_cyc.size();
        run_job(0, 1, 5, 10);
        repeat (6) @(posedge clk_i);
        #1;
        total++; if (tmo || done_cyc[db] - t0 != 1) begin bad++; $display("FAIL zero_done: got cycle %0d want 1", done_cyc[db] - t0); end
        total++; if (done_cyc.size() - db != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_cyc.size() - db); end
        total++; if (busy_cnt != bb) begin bad++; $display("FAIL zero_busy: got %0d busy cycles want 0", busy_cnt - bb); end
        total++; if (rd_cyc.size() != rb || wr_cyc.size() != wb) begin
            bad++; $display("FAIL zero_traffic: got reads=%0d writes=%0d want 0/0", rd_cyc.size() - rb, wr_cyc.size() - wb); end
    endtask

    task automatic test_ignored_start();
        int wb, lv, nw, errs, fi;
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        wb = wr_cyc.size(); lv = layer_viol;
        run_job(8, 1, 3, 40);
        nw = wr_cyc.size() - wb;
        total++; if (layer_viol != lv) begin bad++; $display("FAIL ign_layer: got %0d cycles off layer 1 want 0", layer_viol - lv); end
        total++; if (nw != 8) begin bad++; $display("FAIL ign_wr_count: got %0d want 8", nw); end
        errs = 0; fi = -1;
        for (int i = 0; i < nw; i++)
            if (wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'd1, src[i])) begin errs++; if (fi < 0) fi = i; end
        total++; if (errs != 0) begin bad++; $display("FAIL ign_data: write %0d got addr=%0d data=%0h want addr=%0d data=%0h",
            fi, wr_adr[wb+fi], wr_dat[wb+fi], fi, lut(2'd1, src[fi])); end
        total++; if (tmo || done_cyc[$] - t0 != 12) begin bad++; $display("FAIL ign_done: got cycle %0d want 12", done_cyc[$] - t0); end
    endtask

    task automatic test_reset_midjob();
        int wb, rb, n_after, r_after, nw, errs, fi;
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        wb = wr_cyc.size(); rb = rd_cyc.size();
        run_job(8, 2, 4, 30);
        n_after = 0; r_after = 0;
        for (int i = wb; i < wr_cyc.size(); i++) if (wr_cyc[i] - t0 >= 6) n_after++;
        for (int i = rb; i < rd_cyc.size(); i++) if (rd_cyc[i] - t0 >= 6) r_after++;
        total++; if (!tmo) begin bad++; $display("FAIL rst_no_done: got done want none"); end
        total++; if (snap !== '0) begin bad++; $display("FAIL rst_outputs: got %h want 0", snap); end
        total++; if (wr_cyc.size() - wb != 2) begin bad++; $display("FAIL rst_pre_writes: got %0d want 2", wr_cyc.size() - wb); end
        total++; if (n_after != 0 || r_after != 0) begin
            bad++; $display("FAIL rst_after: got writes=%0d reads=%0d want 0/0", n_after, r_after); end
        wb = wr_cyc.size();
        run_job(4, 0, 0, 30);
        nw = wr_cyc.size() - wb;
        total++; if (tmo || nw != 4) begin bad++; $display("FAIL rst_rerun_count: got %0d timeout=%0d want 4/0", nw, tmo); end
        errs = 0; fi = -1;
        for (int i = 0; i < nw; i++)
            if (wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'd0, src[i])) begin errs++; if (fi < 0) fi = i; end
        total++; if (errs != 0) begin bad++; $display("FAIL rst_rerun_data: write %0d got addr=%0d data=%0h want addr=%0d data=%0h",
            fi, wr_adr[wb+fi], wr_dat[wb+fi], fi, lut(2'd0, src[fi])); end
        total++; if (tmo || done_cyc[$] - t0 != 8) begin bad++; $display("FAIL rst_rerun_done: got cycle %0d want 8", done_cyc[$] - t0); end
    endtask

    task automatic test_max_len();
        int rb, wb, nr, nw, errs, fi, lay, len;
        for (int r = 0; r < 2; r++) begin
            len = (r == 0) ? 1024 : 1500;
            lay = $urandom_range(0, 3);
            for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
            rb = rd_cyc.size(); wb = wr_cyc.size();
            run_job(len, lay, 0, 1100);
            nr = rd_cyc.size() - rb; nw = wr_cyc.size() - wb;
            total++; if (tmo || nr != 1024 || rd_adr[$] != 1023) begin
                bad++; $display("FAIL max_reads len=%0d: got %0d reads last addr %0d want 1024/1023", len, nr, rd_adr[$]); end
            total++; if (tmo || done_cyc[$] - t0 != 1028) begin
                bad++; $display("FAIL max_done len=%0d: got cycle %0d want 1028", len, done_cyc[$] - t0); end
            errs = 0; fi = -1;
            for (int i = 0; i < nw; i++)
                if (wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'(lay), src[i])) begin errs++; if (fi < 0) fi = i; end
            total++; if (nw != 1024 || errs != 0) begin
                bad++; $display("FAIL max_writes len=%0d: got %0d writes %0d bad want 1024/0", len, nw, errs); end
        end
    endtask

    task automatic test_random();
        int wb, nw, len, lay, errs, fi, cv, sv;
        cv = credit_viol; sv = stab_viol;
        for (int j = 0; j < 15; j++) begin
            len = $urandom_range(1, 40); lay = $urandom_range(0, 3);
            for (int i = 0; i < len; i++) src[i] = 8'($urandom);
            wb = wr_cyc.size();
            run_job(len, lay, 2, 600);
            nw = wr_cyc.size() - wb;
            total++; if (tmo || nw != len) begin
                bad++; $display("FAIL rand_count job %0d: got %0d writes timeout=%0d want %0d", j, nw, tmo, len); end
            errs = 0; fi = -1;
            for (int i = 0; i < nw; i++)
                if (wr_adr[wb+i] != i || wr_dat[wb+i] !== lut(2'(lay), src[i])) begin errs++; if (fi < 0) fi = i; end
            total++; if (errs != 0) begin bad++; $display("FAIL rand_data job %0d: write %0d got addr=%0d data=%0h want addr=%0d data=%0h",
                j, fi, wr_adr[wb+fi], wr_dat[wb+fi], fi, lut(2'(lay), src[fi])); end
            total++; if (tmo || done_cyc[$] - wr_cyc[$] != 1) begin
                bad++; $display("FAIL rand_done job %0d: got %0d cycles after last write want 1", j, done_cyc[$] - wr_cyc[$]); end
        end
        total++; if (credit_viol != cv) begin bad++; $display("FAIL rand_credit: got %0d overruns want 0", credit_viol - cv); end
        total++; if (stab_viol != sv) begin bad++; $display("FAIL rand_stable: got %0d changes want 0", stab_viol - sv); end
    endtask

    initial begin
        bus.wr_ready_i = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_ignored_start();
        test_reset_midjob();
        test_max_len();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gelu_stream_ctrl.md
# gelu_stream_ctrl

Job sequencer that runs a contiguous vector of int8 activations through the shared `gelu` LUT block. Per element it reads the source activation buffer, drives the LUT with the job's layer select, and streams results to the destination buffer over a valid/ready write port. It sits between the FFN up-projection output buffer and the down-projection input buffer, and is the only master of the `gelu` instance. A credit-controlled skid FIFO absorbs the fixed 2-cycle read+LUT latency under write backpressure.

## Interface
- `DEPTH`, 1024, max elements per job (buffer depth)
- `ADDR_W`, 10, address width, `$clog2(DEPTH)`
- `FIFO_D`, 4, output skid FIFO depth, must be ≥ 3
- `clk_i`  in  1  single clock, rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  job start; sampled only in IDLE
- `layer_i`  in  2  layer select, latched at start
- `len_i`  in  ADDR_W+1  element count; values > DEPTH are clamped to DEPTH
- `busy_o`  out  1  job in progress
- `done_o`  out  1  one-cycle completion pulse
- `rd_en_o`  out  1  source buffer read strobe
- `rd_addr_o`  out  ADDR_W  source address
- `rd_data_i`  in  8  source data, valid 1 cycle after `rd_en_o`
- `gelu_layer_o`  out  2  to `gelu` `layer_sel_i`
- `gelu_in_o`  out  8  to `gelu` `in_data_i`; combinational from `rd_data_i`
- `gelu_out_i`  in  8  from `gelu` `out_data_o`; valid 1 cycle after `gelu_in_o`
- `wr_valid_o`  out  1  result valid
- `wr_ready_i`  in  1  destination accepts
- `wr_addr_o`  out  ADDR_W  destination address (equal to the source index)
- `wr_data_o`  out  8  GELU result

## Operation
- FSM has four states: IDLE, RUN, DRAIN, DONE.
  - IDLE→RUN when `start_i`=1. Latch layer and clamped length. Clear the read index and the write index.
  - IDLE→DONE when `start_i`=1 and the clamped length is 0.
  - RUN→DRAIN when the last read issues (read index reaches length−1 with `rd_en_o`=1).
  - DRAIN→DONE when the write handshake for index length−1 completes.
  - DONE→IDLE unconditionally after 1 cycle.
- `start_i` is ignored in RUN, DRAIN and DONE. `layer_i` and `len_i` changes are ignored outside IDLE.
- `gelu_layer_o` holds the latched layer for the whole job. In IDLE it retains its last value.
- Read issue happens in RUN only, when `occ + inflight < FIFO_D`.
  - `occ` is the FIFO occupancy at the start of the cycle.
  - `inflight` is the number of reads issued in the two preceding cycles.
  - A handshake in the current cycle frees its credit from the next cycle onward.
- `rd_addr_o` equals the read index; the index increments on each issued read.
- Pipeline for a read issued in cycle t:
  - t+1: `rd_data_i` is valid and drives `gelu_in_o`.
  - t+2: `gelu_out_i` is pushed into the FIFO together with its index.
- FIFO is first-word-fall-through. A push at the end of cycle t+2 is visible on `wr_valid_o`/`wr_data_o`/`wr_addr_o` in cycle t+3.
- Write handshake occurs when `wr_valid_o`=1 and `wr_ready_i`=1 in the same cycle; that entry is popped.
- Results leave in strictly increasing index order, exactly once each. The credit rule guarantees the FIFO never overflows.
- `wr_data_o` and `wr_addr_o` stay stable while `wr_valid_o`=1 and `wr_ready_i`=0.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `rd_en_o`=0, `rd_addr_o`=0, `gelu_layer_o`=0, `wr_valid_o`=0, `wr_addr_o`=0, `wr_data_o`=0. FIFO empty, in-flight reads discarded, state IDLE.
- Reset asserted mid-job: no `wr_valid_o` from the cycle after reset onward. Any read whose data returns after reset is dropped.
- Example: `start_i` sampled at edge of cycle 0, `wr_ready_i` held at 1, length N:
  - `busy_o`=1 in cycles 1..N+3.
  - `rd_en_o` in cycles 1..N.
  - `wr_valid_o` in cycles 4..N+3.
  - `done_o`=1 and `busy_o`=0 in cycle N+4.
- Throughput is 1 element/cycle with no backpressure.
- `len_i`=0: `done_o` in cycle 1, `busy_o` stays 0, no reads, no writes.
- `done_o` is high only in the DONE state. A `start_i` in that same cycle is ignored; the earliest new start is sampled in the following cycle.

## Test plan
- `len_i`=8, `layer_i`=2, `rd_data_i`=address ^ 8'h55, `wr_ready_i`=1.
  - Reads at addresses 0..7 in cycles 1..8.
  - Writes at addresses 0..7 in cycles 4..11, `wr_data_o` = LUT[2][addr ^ 8'h55].
  - `done_o` in cycle 12.
- `len_i`=16 with `wr_ready_i`=0 in cycles 3..12.
  - `occ + inflight` never exceeds 4.
  - `rd_en_o` stalls; writes resume in cycle 13.
  - All 16 results are in order, no duplicates or drops.
  - `done_o` fires exactly 1 cycle after the index-15 handshake.
- `len_i`=0 → `done_o` in cycle 1 only; `rd_en_o` and `wr_valid_o` stay 0.
- Job with `len_i`=8, `layer_i`=1: pulse `start_i` with `len_i`=3, `layer_i`=3 in cycle 4. The pulse is ignored, `gelu_layer_o` stays 1, exactly 8 writes occur.
- `rst_i` asserted in cycle 5 of a `len_i`=8 job.
  - Cycle 6: all outputs at reset values and no writes appear afterwards.
  - A new job with `len_i`=4, `layer_i`=0 then completes correctly.
- `len_i`=1024 → last `rd_addr_o`=1023, `done_o` in cycle 1028. `len_i`=1500 behaves identically to 1024.
